// File: rtl/csr_access_sequencer.sv
// CSR instruction sequencer: runs read-modify-write sequences against the CSR file
// and performs trap entry (EPC, CAUSE, vector fetch, PC redirect) on interrupts.
module csr_access_sequencer #(
    parameter int unsigned       XLEN        = 32,
    parameter int unsigned       CSR_AW      = 4,
    parameter logic [CSR_AW-1:0] EPC_IDX     = 4'd1,
    parameter logic [CSR_AW-1:0] CAUSE_IDX   = 4'd2,
    parameter logic [CSR_AW-1:0] VEC_IDX     = 4'd8,
    parameter logic [XLEN-1:0]   CAUSE_VALUE = 32'h8000000B
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [CSR_AW-1:0] req_csr,
    input  logic [XLEN-1:0]   req_operand,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    input  logic              irq_pending,
    input  logic [XLEN-1:0]   trap_pc,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [CSR_AW-1:0] csr_read_addr,
    input  logic [XLEN-1:0]   csr_read_data,
    output logic [CSR_AW-1:0] csr_write_addr,
    output logic [XLEN-1:0]   csr_write_data,
    output logic              csr_write_enable,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_RSP, S_T_EPC, S_T_CAUSE, S_T_VEC
    } state_t;

    typedef enum logic [1:0] {
        OP_READ = 2'd0, OP_RW = 2'd1, OP_RS = 2'd2, OP_RC = 2'd3
    } op_t;

    state_t              state_q;
    op_t                 op_q;
    logic [CSR_AW-1:0]   csr_q;
    logic [XLEN-1:0]     operand_q;
    logic [XLEN-1:0]     old_q;
    logic [CSR_AW-1:0]   raddr_q;
    logic [CSR_AW-1:0]   waddr_q;
    logic [XLEN-1:0]     wdata_q;
    logic                we_q;
    logic                rsp_valid_q;
    logic [XLEN-1:0]     rsp_data_q;
    logic                redirect_q;

    logic [XLEN-1:0]     new_d;
    logic                wr_en_d;

    // New value is computed from the live read data during RD so the write can be
    // presented from registers in WR.
    always_comb begin
        new_d   = '0;
        wr_en_d = 1'b0;
        unique case (op_q)
            OP_READ: begin
                new_d   = csr_read_data;
                wr_en_d = 1'b0;
            end
            OP_RW: begin
                new_d   = operand_q;
                wr_en_d = 1'b1;
            end
            OP_RS: begin
                new_d   = csr_read_data | operand_q;
                wr_en_d = (operand_q != '0);
            end
            OP_RC: begin
                new_d   = csr_read_data & ~operand_q;
                wr_en_d = (operand_q != '0);
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_READ;
            csr_q       <= '0;
            operand_q   <= '0;
            old_q       <= '0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            redirect_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (irq_pending) begin
                        we_q    <= 1'b1;
                        waddr_q <= EPC_IDX;
                        wdata_q <= trap_pc;
                        state_q <= S_T_EPC;
                    end else if (req_valid) begin
                        op_q      <= op_t'(req_op);
                        csr_q     <= req_csr;
                        operand_q <= req_operand;
                        raddr_q   <= req_csr;
                        state_q   <= S_RD;
                    end
                end
                S_RD: begin
                    old_q   <= csr_read_data;
                    raddr_q <= '0;
                    we_q    <= wr_en_d;
                    waddr_q <= wr_en_d ? csr_q : '0;
                    wdata_q <= wr_en_d ? new_d : '0;
                    state_q <= S_WR;
                end
                S_WR: begin
                    we_q        <= 1'b0;
                    waddr_q     <= '0;
                    wdata_q     <= '0;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= old_q;
                    state_q     <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                S_T_EPC: begin
                    waddr_q <= CAUSE_IDX;
                    wdata_q <= CAUSE_VALUE;
                    state_q <= S_T_CAUSE;
                end
                S_T_CAUSE: begin
                    we_q       <= 1'b0;
                    waddr_q    <= '0;
                    wdata_q    <= '0;
                    raddr_q    <= VEC_IDX;
                    redirect_q <= 1'b1;
                    state_q    <= S_T_VEC;
                end
                S_T_VEC: begin
                    raddr_q    <= '0;
                    redirect_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = (state_q == S_IDLE) && !irq_pending;
    assign busy           = (state_q != S_IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign redirect_valid = redirect_q;
    // Vector arrives combinationally in T_VEC; low bits are forced for alignment.
    assign redirect_pc    = redirect_q ? {csr_read_data[XLEN-1:2], 2'b00} : '0;
    assign csr_read_addr  = raddr_q;
    assign csr_write_addr = waddr_q;
    assign csr_write_data = wdata_q;
    // Reset blocks a write already registered for this cycle, so an abandoned
    // sequence never commits.
    assign csr_write_enable = we_q & ~reset;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Directed bench for csr_access_sequencer with a behavioural 16-entry CSR file.
module tb_csr_access_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [3:0]  req_csr = '0;
    logic [31:0] req_operand = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        irq_pending = 1'b0;
    logic [31:0] trap_pc = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  csr_read_addr;
    logic [31:0] csr_read_data;
    logic [3:0]  csr_write_addr;
    logic [31:0] csr_write_data;
    logic        csr_write_enable;
    logic        busy;

    logic [31:0] mem [16];
    logic        tb_init = 1'b1;
    int          wr_count = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    csr_access_sequencer #(
        .XLEN(32),
        .CSR_AW(4),
        .EPC_IDX(4'd1),
        .CAUSE_IDX(4'd2),
        .VEC_IDX(4'd8),
        .CAUSE_VALUE(32'h8000000B)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_csr(req_csr), .req_operand(req_operand),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .irq_pending(irq_pending), .trap_pc(trap_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_read_addr(csr_read_addr), .csr_read_data(csr_read_data),
        .csr_write_addr(csr_write_addr), .csr_write_data(csr_write_data),
        .csr_write_enable(csr_write_enable), .busy(busy)
    );

    assign csr_read_data = mem[csr_read_addr];

    always @(posedge clock) begin
        if (tb_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[3]  <= 32'h000000F0;
            mem[5]  <= 32'h00001234;
            mem[6]  <= 32'hFF00FF00;
            mem[7]  <= 32'h00000055;
            mem[8]  <= 32'h40000100;
            mem[10] <= 32'h00000001;
        end else if (csr_write_enable) begin
            mem[csr_write_addr] <= csr_write_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic test_reset();
        reset = 1'b1; tb_init = 1'b1;
        repeat (2) @(negedge clock);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if ({rsp_valid, redirect_valid, csr_write_enable} !== 3'b000) begin bad++; $display("FAIL reset_valids got=%b exp=000", {rsp_valid, redirect_valid, csr_write_enable}); end
        total++; if ({csr_read_addr, csr_write_addr, csr_write_data, rsp_data} !== '0) begin bad++; $display("FAIL reset_addr_data raddr=%0h waddr=%0h wdata=%0h rdata=%0h exp=0", csr_read_addr, csr_write_addr, csr_write_data, rsp_data); end
        irq_pending = 1'b1; #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_irq_ready got=%0b exp=0", req_ready); end
        irq_pending = 1'b0;
        tb_init = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_rs();
        @(negedge clock);
        req_valid = 1'b1; req_op = 2'd2; req_csr = 4'd3; req_operand = 32'h0F; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rs_ready got=%0b exp=1", req_ready); end
        @(negedge clock); req_valid = 1'b0;
        total++; if (busy !== 1'b1 || csr_read_addr !== 4'd3 || csr_write_enable !== 1'b0) begin bad++; $display("FAIL rs_rd busy=%0b raddr=%0h we=%0b exp=1/3/0", busy, csr_read_addr, csr_write_enable); end
        @(negedge clock);
        total++; if (csr_write_enable !== 1'b1 || csr_write_addr !== 4'd3 || csr_write_data !== 32'hFF) begin bad++; $display("FAIL rs_wr we=%0b addr=%0h data=%0h exp=1/3/ff", csr_write_enable, csr_write_addr, csr_write_data); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rs_early_rsp got=%0b exp=0", rsp_valid); end
        @(negedge clock);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hF0) begin bad++; $display("FAIL rs_rsp valid=%0b data=%0h exp=1/f0", rsp_valid, rsp_data); end
        total++; if (mem[3] !== 32'hFF) begin bad++; $display("FAIL rs_mem got=%0h exp=ff", mem[3]); end
        rsp_ready = 1'b1;
        @(negedge clock); rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rs_done valid=%0b busy=%0b exp=0/0", rsp_valid, busy); end
    endtask

    task automatic test_rc();
        int w0;
        w0 = wr_count;
        @(negedge clock);
        req_valid = 1'b1; req_op = 2'd3; req_csr = 4'd5; req_operand = 32'h0;
        repeat (3) begin @(negedge clock); req_valid = 1'b0; end
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234) begin bad++; $display("FAIL rc0_rsp valid=%0b data=%0h exp=1/1234", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clock); rsp_ready = 1'b0;
        total++; if (wr_count !== w0 || mem[5] !== 32'h1234) begin bad++; $display("FAIL rc0_nowrite writes=%0d mem=%0h exp=%0d/1234", wr_count, mem[5], w0); end
        req_valid = 1'b1; req_op = 2'd3; req_csr = 4'd6; req_operand = 32'h0F000F00;
        @(negedge clock); req_valid = 1'b0;
        @(negedge clock);
        total++; if (csr_write_enable !== 1'b1 || csr_write_addr !== 4'd6 || csr_write_data !== 32'hF000F000) begin bad++; $display("FAIL rc_wr we=%0b addr=%0h data=%0h exp=1/6/f000f000", csr_write_enable, csr_write_addr, csr_write_data); end
        @(negedge clock);
        total++; if (rsp_data !== 32'hFF00FF00) begin bad++; $display("FAIL rc_rsp got=%0h exp=ff00ff00", rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clock); rsp_ready = 1'b0;
    endtask

    task automatic test_rw_stall();
        @(negedge clock);
        req_valid = 1'b1; req_op = 2'd1; req_csr = 4'd7; req_operand = 32'hDEADBEEF;
        @(negedge clock); req_valid = 1'b0;
        @(negedge clock);
        total++; if (csr_write_data !== 32'hDEADBEEF || csr_write_enable !== 1'b1) begin bad++; $display("FAIL rw_wr data=%0h we=%0b exp=deadbeef/1", csr_write_data, csr_write_enable); end
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h55 || busy !== 1'b1) begin bad++; $display("FAIL rw_hold%0d valid=%0b data=%0h busy=%0b exp=1/55/1", i, rsp_valid, rsp_data, busy); end
            @(negedge clock);
        end
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h55) begin bad++; $display("FAIL rw_hold_end valid=%0b data=%0h exp=1/55", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clock); rsp_ready = 1'b0;
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || mem[7] !== 32'hDEADBEEF) begin bad++; $display("FAIL rw_done busy=%0b valid=%0b mem=%0h exp=0/0/deadbeef", busy, rsp_valid, mem[7]); end
    endtask

    task automatic test_trap();
        @(negedge clock);
        irq_pending = 1'b1; req_valid = 1'b1; req_op = 2'd0; req_csr = 4'd2; trap_pc = 32'h00001004; #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL trap_ready got=%0b exp=0", req_ready); end
        @(negedge clock);
        total++; if (csr_write_enable !== 1'b1 || csr_write_addr !== 4'd1 || csr_write_data !== 32'h00001004) begin bad++; $display("FAIL trap_epc we=%0b addr=%0h data=%0h exp=1/1/1004", csr_write_enable, csr_write_addr, csr_write_data); end
        irq_pending = 1'b0;
        @(negedge clock);
        total++; if (csr_write_enable !== 1'b1 || csr_write_addr !== 4'd2 || csr_write_data !== 32'h8000000B) begin bad++; $display("FAIL trap_cause we=%0b addr=%0h data=%0h exp=1/2/8000000b", csr_write_enable, csr_write_addr, csr_write_data); end
        @(negedge clock);
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40000100 || csr_write_enable !== 1'b0) begin bad++; $display("FAIL trap_redirect valid=%0b pc=%0h we=%0b exp=1/40000100/0", redirect_valid, redirect_pc, csr_write_enable); end
        total++; if (mem[1] !== 32'h00001004 || mem[2] !== 32'h8000000B) begin bad++; $display("FAIL trap_mem epc=%0h cause=%0h exp=1004/8000000b", mem[1], mem[2]); end
        @(negedge clock);
        total++; if (redirect_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL trap_after redirect=%0b ready=%0b exp=0/1", redirect_valid, req_ready); end
        @(negedge clock); req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h8000000B) begin bad++; $display("FAIL trap_readcause valid=%0b data=%0h exp=1/8000000b", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clock); rsp_ready = 1'b0;
    endtask

    task automatic test_irq_during_rsp();
        @(negedge clock);
        req_valid = 1'b1; req_op = 2'd1; req_csr = 4'd8; req_operand = 32'h40000203;
        @(negedge clock); req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40000100) begin bad++; $display("FAIL irqrsp_rsp valid=%0b data=%0h exp=1/40000100", rsp_valid, rsp_data); end
        irq_pending = 1'b1; trap_pc = 32'h00002000;
        @(negedge clock);
        total++; if (rsp_valid !== 1'b1 || csr_write_enable !== 1'b0 || redirect_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL irqrsp_wait valid=%0b we=%0b redir=%0b busy=%0b exp=1/0/0/1", rsp_valid, csr_write_enable, redirect_valid, busy); end
        rsp_ready = 1'b1;
        @(negedge clock); rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL irqrsp_idle valid=%0b busy=%0b ready=%0b exp=0/0/0", rsp_valid, busy, req_ready); end
        @(negedge clock);
        total++; if (csr_write_enable !== 1'b1 || csr_write_addr !== 4'd1 || csr_write_data !== 32'h00002000) begin bad++; $display("FAIL irqrsp_epc we=%0b addr=%0h data=%0h exp=1/1/2000", csr_write_enable, csr_write_addr, csr_write_data); end
        irq_pending = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40000200) begin bad++; $display("FAIL irqrsp_redirect valid=%0b pc=%0h exp=1/40000200", redirect_valid, redirect_pc); end
        @(negedge clock);
        total++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin bad++; $display("FAIL irqrsp_end busy=%0b redir=%0b exp=0/0", busy, redirect_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        req_valid = 1'b1; req_op = 2'd1; req_csr = 4'd10; req_operand = 32'h0000AAAA;
        @(negedge clock); req_valid = 1'b0;
        @(negedge clock);
        total++; if (csr_write_enable !== 1'b1) begin bad++; $display("FAIL rstmid_inwr we=%0b exp=1", csr_write_enable); end
        reset = 1'b1; #1;
        total++; if (csr_write_enable !== 1'b0) begin bad++; $display("FAIL rstmid_gate we=%0b exp=0", csr_write_enable); end
        @(negedge clock);
        reset = 1'b0; #1;
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || csr_write_enable !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_outs busy=%0b valid=%0b we=%0b ready=%0b exp=0/0/0/1", busy, rsp_valid, csr_write_enable, req_ready); end
        total++; if ({csr_read_addr, csr_write_addr, csr_write_data} !== '0) begin bad++; $display("FAIL rstmid_addr raddr=%0h waddr=%0h wdata=%0h exp=0", csr_read_addr, csr_write_addr, csr_write_data); end
        total++; if (mem[10] !== 32'h1) begin bad++; $display("FAIL rstmid_mem got=%0h exp=1", mem[10]); end
        @(negedge clock);
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_drop valid=%0b busy=%0b exp=0/0", rsp_valid, busy); end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 2'd0; req_csr = 4'd3; req_operand = '0;
        for (int i = 0; i < 9; i++) begin
            if (req_valid && req_ready) acc.push_back(i);
            if (i == 3) begin
                total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hFF) begin bad++; $display("FAIL b2b_rsp valid=%0b data=%0h exp=1/ff", rsp_valid, rsp_data); end
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        total++; if (acc.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", acc.size()); end
        if (acc.size() >= 2) begin
            total++; if (acc[1] - acc[0] !== 4) begin bad++; $display("FAIL b2b_interval got=%0d exp=4", acc[1] - acc[0]); end
        end
        repeat (4) @(negedge clock);
        rsp_ready = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain busy=%0b exp=0", busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rs();
        test_rc();
        test_rw_stall();
        test_trap();
        test_irq_during_rsp();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
